// File: rtl/io_cfg_loader_pkg.sv
// Shared definitions for the IO-block configuration chain loader.
package io_cfg_loader_pkg;

  // Config bits held by one IO block: 8 switches x 2-bit enable_dir.
  localparam int CFG_BITS_PER_IO = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    WAIT_RET,
    DONE,
    ERR
  } state_e;

  // Total bits that must travel down the chain in one session.
  function automatic int calc_total_bits(input int num_io, input int bits_per_io);
    return num_io * bits_per_io;
  endfunction

  // Host words per session; total bits is expected to be a whole number of words.
  function automatic int calc_num_words(input int total_bits, input int word_w);
    return total_bits / word_w;
  endfunction

endpackage

// File: rtl/io_cfg_serializer.sv
// Word shift register plus bit counter feeding the config chain LSB-first.
// nxt_bit_o is the bit that goes on the wire in the following cycle, so the
// parent can register bit_out alongside the strobe.
module io_cfg_serializer #(
  parameter int WORD_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] din_i,
  output logic              nxt_bit_o,
  output logic              last_o
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  // Load a fresh word or advance one bit; the counter saturates at WORD_W.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (load_i) begin
      shreg_d   = din_i;
      bit_cnt_d = '0;
    end else if (shift_i && (bit_cnt_q != CNT_W'(WORD_W))) begin
      shreg_d   = shreg_q >> 1;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // While shifting, shreg_q[0] is the bit currently on the wire, so the next
  // one is shreg_q[1]; on load the first bit comes straight from din_i.
  assign nxt_bit_o = load_i ? din_i[0] : shreg_q[1];
  assign last_o    = (bit_cnt_q == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/io_cfg_loader.sv
// Transmit end of the IO-block configuration chain: takes host words,
// serialises them onto the chain with strobes, and checks the returned token.
module io_cfg_loader
  import io_cfg_loader_pkg::*;
#(
  parameter int NUM_IO      = 4,
  parameter int BITS_PER_IO = CFG_BITS_PER_IO,
  parameter int WORD_W      = 16,
  parameter int RET_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              bit_out,
  output logic              prgm_b,
  output logic              io_prgm_b,
  output logic              io_prgm_b_in,
  input  logic              io_prgm_b_ret,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TOTAL_BITS = calc_total_bits(NUM_IO, BITS_PER_IO);
  localparam int NUM_WORDS  = calc_num_words(TOTAL_BITS, WORD_W);
  localparam int WC_W       = $clog2(NUM_WORDS + 1);
  localparam int TM_W       = $clog2(RET_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [WC_W-1:0] word_cnt_q, word_cnt_d;
  logic [TM_W-1:0] timer_q, timer_d;

  logic ser_load, ser_shift, ser_nxt_bit, ser_last;

  logic din_ready_q, bit_out_q, prgm_b_q, io_prgm_b_q, io_prgm_b_in_q;
  logic busy_q, done_q, error_q;
  logic din_ready_d, bit_out_d, busy_d, io_prgm_b_d, done_d, error_d;

  io_cfg_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (ser_load),
    .shift_i   (ser_shift),
    .din_i     (din),
    .nxt_bit_o (ser_nxt_bit),
    .last_o    (ser_last)
  );

  // Session sequencing. A returned token is only legal once every bit has
  // been strobed; seeing it in LOAD or SHIFT aborts the session.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    timer_d    = timer_q;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          word_cnt_d = '0;
          timer_d    = '0;
        end
      end
      LOAD: begin
        if (io_prgm_b_ret) begin
          state_d = ERR;
        end else if (din_valid) begin
          ser_load = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (io_prgm_b_ret) begin
          state_d = ERR;
        end else begin
          ser_shift = 1'b1;
          if (ser_last) begin
            word_cnt_d = word_cnt_q + WC_W'(1);
            timer_d    = '0;
            state_d    = (word_cnt_d < WC_W'(NUM_WORDS)) ? LOAD : WAIT_RET;
          end
        end
      end
      WAIT_RET: begin
        if (io_prgm_b_ret) begin
          state_d = DONE;
        end else begin
          timer_d = timer_q + TM_W'(1);
          if (timer_d == TM_W'(RET_TIMEOUT)) state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop
  // and lines up with the state it belongs to.
  always_comb begin
    busy_d      = (state_d inside {LOAD, SHIFT, WAIT_RET});
    io_prgm_b_d = (state_d == SHIFT);
    bit_out_d   = io_prgm_b_d & ser_nxt_bit;
    din_ready_d = (state_d == LOAD);
    done_d      = (state_d == DONE);
    error_d     = error_q;
    if ((state_q == IDLE) && start) error_d = 1'b0;
    if (state_d == ERR)             error_d = 1'b1;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      word_cnt_q     <= '0;
      timer_q        <= '0;
      din_ready_q    <= 1'b0;
      bit_out_q      <= 1'b0;
      prgm_b_q       <= 1'b0;
      io_prgm_b_q    <= 1'b0;
      io_prgm_b_in_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      timer_q        <= timer_d;
      din_ready_q    <= din_ready_d;
      bit_out_q      <= bit_out_d;
      prgm_b_q       <= busy_d;
      io_prgm_b_q    <= io_prgm_b_d;
      io_prgm_b_in_q <= busy_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign din_ready    = din_ready_q;
  assign bit_out      = bit_out_q;
  assign prgm_b       = prgm_b_q;
  assign io_prgm_b    = io_prgm_b_q;
  assign io_prgm_b_in = io_prgm_b_in_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_io_cfg_loader.sv
// Bench for io_cfg_loader: a per-cycle scoreboard checks the serial stream
// and session invariants, directed sessions check timing and error paths.
module tb_io_cfg_loader;

  localparam int NUM_IO      = 2;
  localparam int BPI         = 16;
  localparam int WORD_W      = 16;
  localparam int RET_TIMEOUT = 8;
  localparam int TOTAL       = NUM_IO * BPI;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              din_valid = 1'b0;
  logic              io_prgm_b_ret = 1'b0;
  logic [WORD_W-1:0] din = '0;
  logic              din_ready, bit_out, prgm_b, io_prgm_b, io_prgm_b_in;
  logic              busy, done, error;

  int         checks = 0;
  int         errors = 0;
  logic       exp_bits[$];
  int         strobes = 0;
  int         done_cnt = 0;
  logic [63:0] seen = '0;

  always #5 clk = ~clk;

  io_cfg_loader #(
    .NUM_IO      (NUM_IO),
    .BITS_PER_IO (BPI),
    .WORD_W      (WORD_W),
    .RET_TIMEOUT (RET_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .bit_out       (bit_out),
    .prgm_b        (prgm_b),
    .io_prgm_b     (io_prgm_b),
    .io_prgm_b_in  (io_prgm_b_in),
    .io_prgm_b_ret (io_prgm_b_ret),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected stream for a session: both words, each LSB first.
  task automatic new_session(input logic [15:0] w0, input logic [15:0] w1);
    exp_bits.delete();
    for (int i = 0; i < WORD_W; i++) exp_bits.push_back(w0[i]);
    for (int i = 0; i < WORD_W; i++) exp_bits.push_back(w1[i]);
    strobes  = 0;
    done_cnt = 0;
    seen     = '0;
  endtask

  // Scoreboard: every strobe carries the next expected bit; idle wire is 0.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("prgm_b_eq_busy", prgm_b, busy);
        chk("tok_in_eq_busy", io_prgm_b_in, busy);
        if (din_ready) begin
          chk("ready_no_strobe", io_prgm_b, 0);
          chk("ready_in_session", busy, 1);
        end
        if (io_prgm_b) begin
          chk("strobe_in_session", busy, 1);
          if (exp_bits.size() == 0) chk("extra_strobe", io_prgm_b, 0);
          else                      chk("bit_out", bit_out, exp_bits.pop_front());
          if (strobes < 64) seen[strobes] = bit_out;
          strobes++;
        end else begin
          chk("bit_out_idle", bit_out, 0);
        end
        if (done) begin
          done_cnt++;
          chk("done_all_bits", strobes, TOTAL);
          chk("done_no_error", error, 0);
        end
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_prgm_b", prgm_b, 1);
    chk("start_tok_in", io_prgm_b_in, 1);
    chk("start_err_clr", error, 0);
    chk("start_ready", din_ready, 1);
  endtask

  task automatic send_word(input logic [15:0] w, input int stall);
    int n = 0;
    while (!din_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", din_ready, 1);
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_ready", din_ready, 1);
      chk("stall_no_strobe", io_prgm_b, 0);
    end
    din       = w;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("first_strobe", io_prgm_b, 1);
    chk("first_bit", bit_out, w[0]);
    chk("ready_drop", din_ready, 0);
  endtask

  // Returns just after the falling edge of the cycle carrying strobe n.
  task automatic wait_strobes(input int n);
    int k = 0;
    while (strobes < n && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    chk("strobe_wait", strobes >= n, 1);
  endtask

  // Token comes back in the cycle after the last strobe; done follows it.
  task automatic finish_ok(input logic [31:0] exp_seen);
    wait_strobes(TOTAL);
    @(posedge clk); #1;
    chk("wait_no_strobe", io_prgm_b, 0);
    chk("wait_busy", busy, 1);
    io_prgm_b_ret = 1'b1;
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_error", error, 0);
    io_prgm_b_ret = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("post_prgm_b", prgm_b, 0);
    chk("post_tok_in", io_prgm_b_in, 0);
    chk("strobe_total", strobes, TOTAL);
    chk("stream", seen[31:0], exp_seen);
    chk("done_count", done_cnt, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, din_ready, 0);
    chk({tag, "_bit"}, bit_out, 0);
    chk({tag, "_prgm_b"}, prgm_b, 0);
    chk({tag, "_strobe"}, io_prgm_b, 0);
    chk({tag, "_tok_in"}, io_prgm_b_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    int k;
    fork
      compare_loop();
    join_none

    reset = 1'b1;
    #12;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Nominal session; stream is 0xA5C3 then 0x0F0F, LSB first.
    new_session(16'hA5C3, 16'h0F0F);
    do_start();
    send_word(16'hA5C3, 0);
    send_word(16'h0F0F, 0);
    finish_ok(32'h0F0F_A5C3);

    // Host stalls 5 cycles before the second word.
    new_session(16'hBEEF, 16'h0001);
    do_start();
    send_word(16'hBEEF, 0);
    send_word(16'h0001, 5);
    finish_ok(32'h0001_BEEF);

    // Token never returns: error rises 8 edges after the edge that samples
    // the last bit.
    new_session(16'h3C96, 16'h8001);
    do_start();
    send_word(16'h3C96, 0);
    send_word(16'h8001, 0);
    wait_strobes(TOTAL);
    @(posedge clk); #1;
    k = 0;
    while (!error && k < 20) begin
      chk("timeout_busy", busy, 1);
      @(posedge clk); #1;
      k++;
    end
    chk("timeout_cycles", k, RET_TIMEOUT);
    chk("timeout_busy_low", busy, 0);
    chk("timeout_prgm_b", prgm_b, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("error_sticky", error, 1);
    chk("timeout_no_done", done_cnt, 0);
    chk("timeout_strobes", strobes, TOTAL);

    // Early token during the 10th strobe; start also clears the sticky error.
    new_session(16'h5A5A, 16'hFFFF);
    do_start();
    send_word(16'h5A5A, 0);
    wait_strobes(10);
    io_prgm_b_ret = 1'b1;
    @(posedge clk); #1;
    chk("early_error", error, 1);
    chk("early_prgm_b", prgm_b, 0);
    chk("early_strobe", io_prgm_b, 0);
    chk("early_busy", busy, 0);
    io_prgm_b_ret = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("early_strobes", strobes, 10);
    chk("early_stream", seen[9:0], 10'h25A);
    chk("early_no_done", done_cnt, 0);
    chk("early_err_hold", error, 1);

    // Reset in the middle of the first word, then a clean session.
    new_session(16'hA5C3, 16'h0F0F);
    do_start();
    send_word(16'hA5C3, 0);
    wait_strobes(7);
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    new_session(16'hA5C3, 16'h0F0F);
    do_start();
    send_word(16'hA5C3, 0);
    send_word(16'h0F0F, 0);
    finish_ok(32'h0F0F_A5C3);

    // start held during SHIFT has no effect.
    new_session(16'h1234, 16'hFFFF);
    do_start();
    send_word(16'h1234, 0);
    start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("restart_busy", busy, 1);
      chk("restart_no_load", din_ready, 0);
    end
    start = 1'b0;
    send_word(16'hFFFF, 0);
    finish_ok(32'hFFFF_1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
